// File: rtl/cymometer_pkg.sv
// Shared widths and FSM state type for the frequency-sweep test source.
package cymometer_pkg;
    localparam int PHASE_W_DEF = 32;
    localparam int DWELL_W_DEF = 28;
    localparam int STEP_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;
endpackage

// File: rtl/sweep_gen_nco_core.sv
// Phase accumulator NCO; clk_out is the registered accumulator MSB.
module nco_core
    import cymometer_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [PHASE_W-1:0] fw,
    output logic               clk_out
);
    logic [PHASE_W-1:0] r_acc;
    logic               r_clk_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
        end else if (clr) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
        end else if (en) begin
            r_acc     <= r_acc + fw;
            r_clk_out <= r_acc[PHASE_W-1];
        end
    end

    assign clk_out = r_clk_out;
endmodule

// File: rtl/sweep_gen.sv
// Stepped-frequency sweep controller driving an NCO test clock.
module sweep_gen
    import cymometer_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int STEP_W  = STEP_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_start_fw,
    input  logic [PHASE_W-1:0] cfg_step_fw,
    input  logic [STEP_W-1:0]  cfg_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               abort,
    output logic               clk_out,
    output logic [PHASE_W-1:0] fw_cur,
    output logic [STEP_W-1:0]  step_idx,
    output logic               busy,
    output logic               done
);
    sweep_state_t r_state;
    sweep_state_t w_next;

    logic [PHASE_W-1:0] r_fw_cur;
    logic [PHASE_W-1:0] r_step_fw;
    logic [STEP_W-1:0]  r_steps;
    logic [STEP_W-1:0]  r_step_idx;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic w_accept;
    logic w_term;
    logic w_last;
    logic w_nco_clr;
    logic w_nco_en;

    assign w_accept = cfg_valid && (r_state == ST_IDLE);
    assign w_term   = (r_dwell_cnt == r_dwell - DWELL_W'(1));
    assign w_last   = (r_step_idx == r_steps - STEP_W'(1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (w_accept) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_term && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Zero steps or dwell is promoted to one so a sweep always terminates.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fw_cur    <= '0;
            r_step_fw   <= '0;
            r_steps     <= STEP_W'(1);
            r_step_idx  <= '0;
            r_dwell     <= DWELL_W'(1);
            r_dwell_cnt <= '0;
        end else if (w_accept) begin
            r_fw_cur    <= cfg_start_fw;
            r_step_fw   <= cfg_step_fw;
            r_steps     <= (cfg_steps == '0) ? STEP_W'(1) : cfg_steps;
            r_dwell     <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
            r_step_idx  <= '0;
            r_dwell_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_term) begin
                r_dwell_cnt <= '0;
                if (!w_last && !abort) begin
                    r_fw_cur   <= r_fw_cur + r_step_fw;
                    r_step_idx <= r_step_idx + STEP_W'(1);
                end
            end else begin
                r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
            end
        end
    end

    // Clearing on any edge that leaves RUN forces clk_out low from that edge.
    assign w_nco_clr = (w_next != ST_RUN);
    assign w_nco_en  = (r_state == ST_RUN);

    nco_core #(
        .PHASE_W (PHASE_W)
    ) u_nco (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .clr     (w_nco_clr),
        .en      (w_nco_en),
        .fw      (r_fw_cur),
        .clk_out (clk_out)
    );

    assign fw_cur   = r_fw_cur;
    assign step_idx = r_step_idx;
endmodule

// File: tb/tb_sweep_gen.sv
// Self-checking bench for sweep_gen against a cycle-indexed sweep model.
module tb_sweep_gen;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_start_fw = '0;
    logic [31:0] cfg_step_fw = '0;
    logic [7:0]  cfg_steps = '0;
    logic [27:0] cfg_dwell = '0;
    logic        abort = 1'b0;
    logic        clk_out;
    logic [31:0] fw_cur;
    logic [7:0]  step_idx;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #10 sys_clk = ~sys_clk;

    sweep_gen dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_start_fw (cfg_start_fw),
        .cfg_step_fw  (cfg_step_fw),
        .cfg_steps    (cfg_steps),
        .cfg_dwell    (cfg_dwell),
        .abort        (abort),
        .clk_out      (clk_out),
        .fw_cur       (fw_cur),
        .step_idx     (step_idx),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_rdy"}, 64'(cfg_ready), 64'd1);
        check({tag, "_clk"}, 64'(clk_out), 64'd0);
        check({tag, "_fw"}, 64'(fw_cur), 64'd0);
        check({tag, "_idx"}, 64'(step_idx), 64'd0);
    endtask

    // Model: RUN cycle n uses step n/dwell; clk_out in cycle n is the MSB
    // of the phase sum over cycles 0..n-2 (zero in cycle 0).
    task automatic sweep(input logic [31:0] st, input logic [31:0] sp,
                         input logic [7:0] ns, input logic [27:0] dw,
                         input int abort_at, input int rst_at);
        int          se, de, n_tot, s;
        logic [31:0] acc, fw;
        logic        exp_clk;
        se    = (ns == 0) ? 1 : int'(ns);
        de    = (dw == 0) ? 1 : int'(dw);
        n_tot = se * de;
        check("idle_ready", 64'(cfg_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        cfg_valid    = 1'b1;
        cfg_start_fw = st;
        cfg_step_fw  = sp;
        cfg_steps    = ns;
        cfg_dwell    = dw;
        abort        = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        cfg_valid = 1'b0;
        abort     = 1'b0;
        acc       = '0;
        exp_clk   = 1'b0;
        fw        = st;
        s         = 0;
        for (int n = 0; n < n_tot; n++) begin
            s  = n / de;
            fw = st + sp * 32'(s);
            check("run_busy", 64'(busy), 64'd1);
            check("run_ready", 64'(cfg_ready), 64'd0);
            check("run_done", 64'(done), 64'd0);
            check("run_fw", 64'(fw_cur), 64'(fw));
            check("run_idx", 64'(step_idx), 64'(s));
            check("run_clk", 64'(clk_out), 64'(exp_clk));
            if (n == rst_at) begin
                sys_rst_n = 1'b0;
                #1;
                check_reset_vals("rst_async");
                @(posedge sys_clk);
                #1;
                check_reset_vals("rst_hold");
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
                return;
            end
            if (n == abort_at) begin
                abort = 1'b1;
                @(negedge sys_clk);
                abort = 1'b0;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_ready", 64'(cfg_ready), 64'd1);
                check("abort_done", 64'(done), 64'd0);
                check("abort_clk", 64'(clk_out), 64'd0);
                check("abort_fw", 64'(fw_cur), 64'(fw));
                check("abort_idx", 64'(step_idx), 64'(s));
                @(negedge sys_clk);
                check("abort_nodone", 64'(done), 64'd0);
                return;
            end
            cfg_valid    = 1'($urandom_range(0, 1));
            cfg_start_fw = $urandom;
            exp_clk      = acc[31];
            acc          = acc + fw;
            @(negedge sys_clk);
            cfg_valid = 1'b0;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_ready", 64'(cfg_ready), 64'd0);
        check("done_clk", 64'(clk_out), 64'd0);
        check("done_fw", 64'(fw_cur), 64'(fw));
        check("done_idx", 64'(step_idx), 64'(se - 1));
        abort = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        abort = 1'b0;
        check("post_done", 64'(done), 64'd0);
        check("post_ready", 64'(cfg_ready), 64'd1);
        check("post_busy", 64'(busy), 64'd0);
        check("post_clk", 64'(clk_out), 64'd0);
        check("post_fw", 64'(fw_cur), 64'(fw));
        check("post_idx", 64'(step_idx), 64'(se - 1));
    endtask

    initial begin
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_vals("por");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_reset_vals("idle");

        sweep(32'h2000_0000, 32'h0, 8'd1, 28'd64, -1, -1);
        sweep(32'h8000_0000, 32'h0, 8'd1, 28'd8, -1, -1);
        sweep(32'h1000_0000, 32'h1000_0000, 8'd3, 28'd16, -1, -1);
        sweep(32'hF000_0000, 32'h2000_0000, 8'd2, 28'd4, -1, -1);
        sweep($urandom, $urandom, 8'd3, 28'd8, 10, -1);
        sweep(32'h3000_0000, 32'h0000_0100, 8'd2, 28'd8, -1, 5);
        sweep(32'h4000_0000, 32'h1234_5678, 8'd0, 28'd0, -1, -1);
        for (int k = 0; k < 8; k++) begin
            sweep($urandom, $urandom, 8'($urandom_range(0, 4)),
                  28'($urandom_range(0, 9)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
                  -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sweep_gen.md
SWEEP_GEN -- requirements
Module: sweep_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator and frequency-word width.
REQ-002 SHALL have parameter DWELL_W, default 28: dwell counter width.
REQ-003 SHALL have parameter STEP_W, default 8: step counter width.
REQ-004 SHALL have port sys_clk, input, 1: single clock, 50 MHz; all logic in this domain.
REQ-005 SHALL have port sys_rst_n, input, 1: reset; one clock, asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1: configuration request.
REQ-007 SHALL have port cfg_ready, output, 1: block can accept a configuration.
REQ-008 SHALL have port cfg_start_fw, input, PHASE_W: first frequency word.
REQ-009 SHALL have port cfg_step_fw, input, PHASE_W: frequency-word increment per step.
REQ-010 SHALL have port cfg_steps, input, STEP_W: number of frequency steps.
REQ-011 SHALL have port cfg_dwell, input, DWELL_W: sys_clk cycles per step.
REQ-012 SHALL have port abort, input, 1: terminate the sweep.
REQ-013 SHALL have port clk_out, output, 1: generated test clock for the frequency meter input.
REQ-014 SHALL have port fw_cur, output, PHASE_W: frequency word in use.
REQ-015 SHALL have port step_idx, output, STEP_W: index of the current step.
REQ-016 SHALL have port busy, output, 1: sweep in progress.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when a sweep completes normally.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
REQ-019 In IDLE, SHALL drive cfg_ready=1, busy=0, accumulator=0 and clk_out=0.
REQ-020 On cfg_valid&&cfg_ready, SHALL in the same edge latch all cfg_* fields, set fw_cur=cfg_start_fw, set step_idx=0, clear the dwell counter and accumulator, and enter RUN.
REQ-021 SHALL treat cfg_steps=0 as 1 and cfg_dwell=0 as 1.
REQ-022 In RUN, SHALL drive cfg_ready=0 and busy=1, and ignore cfg_valid.
REQ-023 In RUN, on every cycle SHALL update acc <= acc + fw_cur, modulo 2^PHASE_W.
REQ-024 SHALL register clk_out <= acc[PHASE_W-1], giving one cycle of latency, so f_out = fw_cur*f_sys/2^PHASE_W.
REQ-025 In RUN, the dwell counter SHALL count 0..dwell-1.
REQ-026 At the dwell-counter terminal count with step_idx<steps-1, SHALL update fw_cur <= fw_cur + step_fw (wrap modulo 2^PHASE_W), increment step_idx, clear the dwell counter, and leave the accumulator uncleared so phase stays continuous.
REQ-027 At the dwell-counter terminal count with step_idx==steps-1, SHALL enter DONE.
REQ-028 DONE SHALL last exactly one cycle: done=1, busy=0, accumulator cleared, clk_out<=0; the next state SHALL be IDLE.
REQ-029 abort=1 in RUN SHALL force IDLE at the next edge, with no done pulse and clk_out=0 from that edge.
REQ-030 abort in IDLE or DONE SHALL have no effect; cfg_valid together with abort in IDLE SHALL accept the configuration.
REQ-031 fw_cur and step_idx SHALL hold their last values in IDLE until the next accepted configuration.

Reset
REQ-032 While sys_rst_n=0, SHALL hold state=IDLE, acc=0, clk_out=0, fw_cur=0, step_idx=0, dwell counter=0, busy=0, done=0 and cfg_ready=1.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep immediately, without a done pulse.
REQ-034 After deassertion, the first configuration SHALL be accepted on the first cycle with cfg_valid=1.

Structure
REQ-035 Package cymometer_pkg SHALL hold PHASE_W/DWELL_W/STEP_W defaults and the FSM state type.
REQ-036 Sub-module nco_core SHALL contain the accumulator and clk_out register, with inputs clr, en and fw.
REQ-037 The FSM, dwell counter and step logic SHALL reside in sweep_gen.

Verification
REQ-038 start=0x2000_0000, steps=1, dwell=64 -> clk_out period 8 cycles (4 high, 4 low), done after 64 RUN cycles.
REQ-039 start=0x8000_0000 -> clk_out toggles every cycle.
REQ-040 start=0x1000_0000, step=0x1000_0000, steps=3, dwell=16 -> fw_cur 0x1000_0000/0x2000_0000/0x3000_0000 for 16 cycles each, step_idx 0/1/2, single done pulse.
REQ-041 start=0xF000_0000, step=0x2000_0000, steps=2 -> second fw_cur=0x1000_0000 (wrap).
REQ-042 abort at RUN cycle 10 -> IDLE next edge, clk_out=0, done never asserted, cfg_ready=1.
REQ-043 sys_rst_n low at RUN cycle 5 -> all outputs at reset values immediately; steps=0, dwell=0 after reset -> one step of one cycle, then done.
